// File: rtl/if_stage_fq.sv
// if_stage_fq: instruction fetch stage with an in-order fetch queue.
// Issues word fetches from a fetch PC under a credit scheme, so every response
// is guaranteed a queue slot. A redirect (flush or taken branch) drains the queue
// and discards responses still in flight. A misaligned PC produces one ADEF entry
// and then stalls fetch.
// Optional feature: define IF_QUEUE_BYPASS_EN to hand a response straight to
// decode in the cycle it arrives when the queue is empty.
module if_stage_fq #(
  parameter logic [31:0] RESET_PC        = 32'h1c00_0000,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          BR_BUS_WD       = 33,
  parameter int          FS_TO_DS_BUS_WD = 65
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [31:0]                new_pc,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       inst_sram_req,
  output logic [31:0]                inst_sram_addr,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata,
  input  logic                       ds_allow_in,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  // Discarded responses can pile up across back-to-back redirects, so this
  // counter is wider than the queue occupancy counters.
  localparam int DIS_W = 8;

  logic                       br_taken;
  logic [31:0]                br_target;
  logic                       redirect;
  logic [31:0]                redirect_pc;

  logic [31:0]                fetch_pc_reg;
  logic                       adef_done_reg;

  logic [FS_TO_DS_BUS_WD-1:0] queue_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]           rd_ptr_reg;
  logic [PTR_W-1:0]           wr_ptr_reg;
  logic [CNT_W-1:0]           count_reg;

  logic [31:0]                pc_fifo_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]           pf_rd_ptr_reg;
  logic [PTR_W-1:0]           pf_wr_ptr_reg;

  logic [CNT_W-1:0]           outstanding_reg;
  logic [DIS_W-1:0]           discard_reg;

  logic [CNT_W:0]             in_use;
  logic                       has_credit;
  logic                       pc_misaligned;
  logic                       issue;
  logic                       discarding;
  logic                       resp_live;
  logic                       queue_empty;
  logic                       adef_push;
  logic                       bypass_valid;
  logic                       bypass_taken;
  logic                       push;
  logic                       pop;
  logic [FS_TO_DS_BUS_WD-1:0] resp_entry;
  logic [FS_TO_DS_BUS_WD-1:0] adef_entry;
  logic [FS_TO_DS_BUS_WD-1:0] push_entry;

  assign br_taken    = br_bus[BR_BUS_WD-1];
  assign br_target   = br_bus[31:0];
  assign redirect    = flush | br_taken;
  assign redirect_pc = flush ? new_pc : br_target;

  // Credits: a request may only go out if its response is sure to find a slot.
  assign in_use        = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign has_credit    = in_use < (CNT_W + 1)'(QUEUE_DEPTH);
  assign pc_misaligned = |fetch_pc_reg[1:0];

  assign inst_sram_req  = !reset && has_credit && !pc_misaligned && !redirect;
  assign inst_sram_addr = fetch_pc_reg;
  assign issue          = inst_sram_req && inst_sram_addr_ok;

  assign discarding  = discard_reg != '0;
  assign resp_live   = !reset && inst_sram_data_ok && !discarding;
  assign queue_empty = count_reg == '0;

  assign resp_entry = FS_TO_DS_BUS_WD'({1'b0, inst_sram_rdata, pc_fifo_mem[pf_rd_ptr_reg]});
  assign adef_entry = FS_TO_DS_BUS_WD'({1'b1, 32'h0, fetch_pc_reg});

  // The ADEF entry waits until every older response has landed or been dropped.
  assign adef_push = !reset && !redirect && pc_misaligned && !adef_done_reg &&
                     (count_reg != CNT_W'(QUEUE_DEPTH)) &&
                     (outstanding_reg == '0) && !discarding;

`ifdef IF_QUEUE_BYPASS_EN
  assign bypass_valid = queue_empty && resp_live && !redirect;
`else
  assign bypass_valid = 1'b0;
`endif

  assign fs_to_ds_valid = !reset && (!queue_empty || bypass_valid);
  assign fs_to_ds_bus   = bypass_valid ? resp_entry : queue_mem[rd_ptr_reg];
  assign bypass_taken   = bypass_valid && ds_allow_in;

  assign pop        = !reset && !queue_empty && ds_allow_in;
  assign push       = !redirect && ((resp_live && !bypass_taken) || adef_push);
  assign push_entry = resp_live ? resp_entry : adef_entry;

  // Fetch PC and ADEF-issued flag; a redirect re-arms fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg  <= RESET_PC;
      adef_done_reg <= 1'b0;
    end else if (redirect) begin
      fetch_pc_reg  <= redirect_pc;
      adef_done_reg <= 1'b0;
    end else begin
      if (issue) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end
      if (adef_push) begin
        adef_done_reg <= 1'b1;
      end
    end
  end

  // In-flight accounting: live requests versus responses to be dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else if (redirect) begin
      // Everything still in flight becomes garbage, minus a response landing now.
      outstanding_reg <= '0;
      discard_reg     <= discard_reg + DIS_W'(outstanding_reg) - DIS_W'(inst_sram_data_ok);
    end else begin
      outstanding_reg <= outstanding_reg + CNT_W'(issue) - CNT_W'(resp_live);
      discard_reg     <= discard_reg - DIS_W'(inst_sram_data_ok && discarding);
    end
  end

  // Queue and PC FIFO pointers plus queue occupancy.
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      pf_rd_ptr_reg <= '0;
      pf_wr_ptr_reg <= '0;
    end else begin
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      if (issue) begin
        pf_wr_ptr_reg <= pf_wr_ptr_reg + PTR_W'(1);
      end
      if (resp_live) begin
        pf_rd_ptr_reg <= pf_rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  // Storage writes; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      queue_mem[wr_ptr_reg] <= push_entry;
    end
    if (issue) begin
      pc_fifo_mem[pf_wr_ptr_reg] <= fetch_pc_reg;
    end
  end

endmodule
